xalulite_ctrl: RTL and testbench

XALULITE_CTRL -- requirements
Module: xalulite_ctrl

---
 rtl/xalulite_ctrl.sv | 155 +++++++++++++++
 tb/tb_xalulite_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/xalulite_ctrl.sv
// xalulite_ctrl: sequencer for a lightweight ALU datapath.
// A run pulse captures the configuration. The block then waits an optional
// delay and issues cfg_iter elements, each with an element index. It tracks
// the two-stage ALU pipeline so that it can flag valid results, drains the
// pipeline, and pulses done.
// Optional feature: define XALULITE_CTRL_REPEAT_EN to add cfg_repeat/rep.
// With that macro the issue phase runs cfg_repeat+1 back-to-back passes.
module xalulite_ctrl #(
    parameter int CNT_W = 10,
    parameter int FNS_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             halt,
    input  logic [FNS_W-1:0] cfg_fns,
    input  logic             cfg_self_loop,
    input  logic [CNT_W-1:0] cfg_iter,
    input  logic [CNT_W-1:0] cfg_delay,
`ifdef XALULITE_CTRL_REPEAT_EN
    input  logic [CNT_W-1:0] cfg_repeat,
    output logic [CNT_W-1:0] rep,
`endif
    output logic [FNS_W-1:0] alu_fns,
    output logic             alu_self_loop,
    output logic             alu_en,
    output logic [CNT_W-1:0] idx,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DELAY = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] iter_q;   // captured element count
    logic [CNT_W-1:0] cnt;      // delay / drain down-counter
    logic [1:0]       vpipe;    // valid bits of ALU input and output registers
    logic             accept;
    logic             last_elem;
    logic             last_pass;

`ifdef XALULITE_CTRL_REPEAT_EN
    logic [CNT_W-1:0] repeat_q;
    assign last_pass = (rep == repeat_q);
`else
    assign last_pass = 1'b1;
`endif

    assign accept    = (state == S_IDLE) && run && !halt;
    // ISSUE is only entered with iter_q > 0, so the subtraction never wraps here.
    assign last_elem = (idx == iter_q - CNT_W'(1));

    // Next-state selection; halt overrides every transition.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps the tool from inferring a latch.
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (run) begin
                    if (cfg_delay != '0)     state_nxt = S_DELAY;
                    else if (cfg_iter != '0) state_nxt = S_ISSUE;
                    else                     state_nxt = S_DONE;
                end
            end
            S_DELAY: begin
                if (cnt == '0) state_nxt = (iter_q != '0) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                if (last_elem && last_pass) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt == '0) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (halt) state_nxt = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Configuration capture, counters, and element index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_fns       <= '0;
            alu_self_loop <= 1'b0;
            iter_q        <= '0;
            cnt           <= '0;
            idx           <= '0;
`ifdef XALULITE_CTRL_REPEAT_EN
            repeat_q      <= '0;
            rep           <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_fns       <= cfg_fns;
                        alu_self_loop <= cfg_self_loop;
                        iter_q        <= cfg_iter;
                        cnt           <= cfg_delay - CNT_W'(1);
                        idx           <= '0;
`ifdef XALULITE_CTRL_REPEAT_EN
                        repeat_q      <= cfg_repeat;
                        rep           <= '0;
`endif
                    end
                end
                S_DELAY: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                S_ISSUE: begin
                    if (last_elem) begin
                        idx <= '0;
                        if (last_pass) cnt <= CNT_W'(1);   // two DRAIN cycles
`ifdef XALULITE_CTRL_REPEAT_EN
                        else           rep <= rep + CNT_W'(1);
`endif
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
            if (halt) idx <= '0;
        end
    end

    // Track the two pipeline stages behind alu_en; halt discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    vpipe <= '0;
        else if (halt) vpipe <= '0;
        else           vpipe <= {vpipe[0], alu_en};
    end

    assign alu_en    = (state == S_ISSUE);
    assign out_valid = vpipe[1];
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_xalulite_ctrl.sv
// Self-checking bench for xalulite_ctrl.
// A job-level timing model predicts every output cycle by cycle.
// Directed scenarios add literal per-cycle expectations on top of the model.
module tb_xalulite_ctrl;

    localparam int CNT_W = 10;
    localparam int FNS_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             run = 1'b0;
    logic             halt = 1'b0;
    logic [FNS_W-1:0] cfg_fns = '0;
    logic             cfg_self_loop = 1'b0;
    logic [CNT_W-1:0] cfg_iter = '0;
    logic [CNT_W-1:0] cfg_delay = '0;
    logic [CNT_W-1:0] cfg_repeat = '0;
    logic [CNT_W-1:0] rep;
    logic [FNS_W-1:0] alu_fns;
    logic             alu_self_loop;
    logic             alu_en;
    logic [CNT_W-1:0] idx;
    logic             out_valid;
    logic             busy;
    logic             done;

    int tests = 0;
    int fails = 0;

    xalulite_ctrl #(.CNT_W(CNT_W), .FNS_W(FNS_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt(halt),
        .cfg_fns(cfg_fns), .cfg_self_loop(cfg_self_loop),
        .cfg_iter(cfg_iter), .cfg_delay(cfg_delay),
`ifdef XALULITE_CTRL_REPEAT_EN
        .cfg_repeat(cfg_repeat), .rep(rep),
`endif
        .alu_fns(alu_fns), .alu_self_loop(alu_self_loop), .alu_en(alu_en),
        .idx(idx), .out_valid(out_valid), .busy(busy), .done(done)
    );

`ifndef XALULITE_CTRL_REPEAT_EN
    assign rep = '0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- job-level model ----------------
    // A job is described by its delay d, element count n, and pass count r+1.
    // Cycle t counts from 1 on the first cycle after the accepting edge.
    // Elements are issued on cycles d+1..d+n*(r+1).
    // Results are valid two cycles after each element.
    // done occurs at d+1 when there is nothing to issue, else at d+N+3.
    logic       m_active = 1'b0;
    int         m_rel = 0, m_d = 0, m_n = 0, m_r = 0;
    logic [3:0] m_fns = '0;
    logic       m_sl = 1'b0;

    function automatic int done_rel(input int d, input int n, input int r);
        int tot = n * (r + 1);
        return (tot == 0) ? d + 1 : d + tot + 3;
    endfunction

    // Model update on each edge, mirroring only job-level rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_rel <= 0; m_fns <= '0; m_sl <= 1'b0;
        end else if (m_active) begin
            if (halt || m_rel == done_rel(m_d, m_n, m_r)) begin
                m_active <= 1'b0; m_rel <= 0;
            end else begin
                m_rel <= m_rel + 1;
            end
        end else if (run && !halt) begin
            m_active <= 1'b1; m_rel <= 1;
            m_d <= int'(cfg_delay); m_n <= int'(cfg_iter);
`ifdef XALULITE_CTRL_REPEAT_EN
            m_r <= int'(cfg_repeat);
`else
            m_r <= 0;
`endif
            m_fns <= cfg_fns; m_sl <= cfg_self_loop;
        end
    end

    // Compare all outputs against the model on every falling edge.
    always @(negedge clk) begin
        int tot, k;
        logic e_en, e_ov;
        tot  = m_n * (m_r + 1);
        k    = m_rel - m_d - 1;
        e_en = m_active && tot > 0 && m_rel >= m_d + 1 && m_rel <= m_d + tot;
        e_ov = m_active && tot > 0 && m_rel >= m_d + 3 && m_rel <= m_d + tot + 2;
        check("m_alu_en", 32'(alu_en), 32'(e_en));
        check("m_idx", 32'(idx), e_en ? k % m_n : 0);
        check("m_out_valid", 32'(out_valid), 32'(e_ov));
        check("m_done", 32'(done), 32'(m_active && m_rel == done_rel(m_d, m_n, m_r)));
        check("m_busy", 32'(busy), 32'(m_active));
        check("m_alu_fns", 32'(alu_fns), 32'(m_fns));
        check("m_alu_self_loop", 32'(alu_self_loop), 32'(m_sl));
`ifdef XALULITE_CTRL_REPEAT_EN
        if (e_en) check("m_rep", 32'(rep), k / m_n);
`endif
    end

    // ---------------- stimulus helpers ----------------
    // Raise run for one cycle. Return #1 into cycle 1, after scrambling cfg_*.
    task automatic start_job(input logic [9:0] d, input logic [9:0] n, input logic [9:0] r,
                             input logic [3:0] f, input logic s);
        @(posedge clk); #1;
        run = 1'b1; cfg_delay = d; cfg_iter = n; cfg_repeat = r; cfg_fns = f; cfg_self_loop = s;
        @(posedge clk); #1;
        run = 1'b0; cfg_fns = ~f; cfg_self_loop = ~s; cfg_iter = 10'd7; cfg_delay = 10'd5;
    endtask

    // Literal expectation for cycle k; bit k of each mask is the expected value.
    task automatic lit(input string tag, input int k, input logic [15:0] en_m,
                       input logic [15:0] ov_m, input logic [15:0] dn_m, input logic [15:0] bz_m);
        check({tag, "_en"}, 32'(alu_en), 32'(en_m[k]));
        check({tag, "_ov"}, 32'(out_valid), 32'(ov_m[k]));
        check({tag, "_done"}, 32'(done), 32'(dn_m[k]));
        check({tag, "_busy"}, 32'(busy), 32'(bz_m[k]));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_outputs", {alu_fns, alu_self_loop, alu_en, idx, out_valid, busy, done}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Job 1: delay 0, 4 elements.
        start_job(10'd0, 10'd4, 10'd0, 4'hA, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            lit("j1", k, 16'b0000_0000_0001_1110, 16'b0000_0000_0111_1000,
                16'b0000_0000_1000_0000, 16'b0000_0000_1111_1110);
            if (k <= 4) check("j1_idx", 32'(idx), k - 1);
        end

        // Job 2: delay 3, 2 elements. A run during DELAY must be ignored.
        start_job(10'd3, 10'd2, 10'd0, 4'h5, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            lit("j2", k, 16'b0000_0000_0011_0000, 16'b0000_0000_1100_0000,
                16'b0000_0001_0000_0000, 16'b0000_0001_1111_1110);
            check("j2_fns", 32'(alu_fns), 32'h5);
            check("j2_self_loop", 32'(alu_self_loop), 32'h0);
            if (k == 2) begin run = 1'b1; cfg_fns = 4'hC; cfg_iter = 10'd9; end
            if (k == 3) run = 1'b0;
        end

        // Job 3: nothing to do, so done arrives on cycle 1.
        start_job(10'd0, 10'd0, 10'd0, 4'h3, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            lit("j3", k, 16'h0, 16'h0, 16'b0000_0000_0000_0010, 16'b0000_0000_0000_0010);
        end

        // Job 4: halt together with run on the 3rd ISSUE cycle.
        start_job(10'd0, 10'd8, 10'd0, 4'h9, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            lit("j4", k, 16'b0000_0000_0000_1110, 16'b0000_0000_0000_1000,
                16'h0, 16'b0000_0000_0000_1110);
            if (k == 3) begin halt = 1'b1; run = 1'b1; cfg_iter = 10'd2; end
            if (k == 4) begin halt = 1'b0; run = 1'b0; check("j4_idx_idle", 32'(idx), 0); end
        end

        // Job 5: assert reset during DRAIN; outputs clear without a clock edge.
        start_job(10'd0, 10'd2, 10'd0, 4'hF, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            lit("j5", k, 16'b0000_0000_0000_0110, 16'b0000_0000_0000_1000,
                16'h0, 16'b0000_0000_0000_1110);
        end
        #2 rst_n = 1'b0;
        #1 check("j5_async_rst", {alu_fns, alu_self_loop, alu_en, idx, out_valid, busy, done}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        start_job(10'd0, 10'd4, 10'd0, 4'h6, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            lit("j5b", k, 16'b0000_0000_0001_1110, 16'b0000_0000_0111_1000,
                16'b0000_0000_1000_0000, 16'b0000_0000_1111_1110);
        end

        // Job 6: full counter range. idx must climb to 1022 without wrapping.
        start_job(10'd0, 10'd1023, 10'd0, 4'h1, 1'b0);
        begin
            int seen = 0;
            for (int k = 1; k <= 1100 && seen == 0; k++) begin
                @(negedge clk);
                if (k == 1023) begin
                    check("j6_last_en", 32'(alu_en), 32'h1);
                    check("j6_last_idx", 32'(idx), 1022);
                end
                if (k == 1024) check("j6_after_en", 32'(alu_en), 32'h0);
                if (done) seen = k;
            end
            check("j6_done_cycle", seen, 1026);
        end

`ifdef XALULITE_CTRL_REPEAT_EN
        // Job 7: 3 elements x 2 passes, no bubble between passes.
        start_job(10'd0, 10'd3, 10'd1, 4'h2, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            lit("j7", k, 16'b0000_0000_0111_1110, 16'b0000_0001_1111_1000,
                16'b0000_0010_0000_0000, 16'b0000_0011_1111_1110);
            if (k <= 6) begin
                check("j7_idx", 32'(idx), (k - 1) % 3);
                check("j7_rep", 32'(rep), (k - 1) / 3);
            end
        end
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
